// File: rtl/servo_pwm_driver_if.sv
// Angle bus in, servo PWM lines out, for the four-channel servo PWM driver.
// The debug field exposes the angles currently latched by the driver.
interface servo_pwm_driver_if;
    // No valid/ready here: the angle words are level signals that the driver
    // may sample on any frame boundary; frame_start marks the cycle after a
    // sample was taken, and the pwm lines are free-running registered outputs.
    logic            enable;
    logic [7:0]      angle1;
    logic [7:0]      angle2;
    logic [7:0]      angle3;
    logic [7:0]      angle4;
    logic            pwm1;
    logic            pwm2;
    logic            pwm3;
    logic            pwm4;
    logic            frame_start;
    logic [3:0][7:0] dbg_cur_angle;

    modport master (
        output enable, angle1, angle2, angle3, angle4,
        input  pwm1, pwm2, pwm3, pwm4, frame_start, dbg_cur_angle
    );

    modport slave (
        input  enable, angle1, angle2, angle3, angle4,
        output pwm1, pwm2, pwm3, pwm4, frame_start, dbg_cur_angle
    );
endinterface

// File: rtl/servo_pwm_driver.sv
// Four-channel 50 Hz hobby-servo PWM generator; angles are latched only at frame boundaries.
// Optional feature macro: SERVO_SLEW_EN limits the per-frame angle change to SLEW_STEP degrees.
module servo_pwm_driver #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int PERIOD_US    = 20000,
    parameter int MIN_PULSE_US = 1000,
    parameter int MAX_PULSE_US = 2000,
    parameter int SLEW_STEP    = 10
) (
    input logic               clk,
    input logic               rst_n,
    servo_pwm_driver_if.slave bus
);
    localparam int DIV   = CLK_HZ / 1_000_000;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int US_TOP = (PERIOD_US > MAX_PULSE_US) ? PERIOD_US : MAX_PULSE_US;
    localparam int US_W  = $clog2(US_TOP + 1);

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIV - 1);
    localparam logic [US_W-1:0]  US_LAST   = US_W'(PERIOD_US - 1);
    localparam logic [US_W-1:0]  PULSE_RST = US_W'(MIN_PULSE_US + (MAX_PULSE_US - MIN_PULSE_US) / 2);
    localparam logic [31:0]      SPAN      = 32'(MAX_PULSE_US - MIN_PULSE_US);
    localparam logic [31:0]      MIN32     = 32'(MIN_PULSE_US);
    localparam logic [7:0]       ANGLE_MAX = 8'd180;
    localparam logic [7:0]       ANGLE_RST = 8'd90;

    if (CLK_HZ % 1_000_000 != 0 || DIV < 1 || SLEW_STEP < 1 || SLEW_STEP > 180 ||
        MAX_PULSE_US < MIN_PULSE_US || MAX_PULSE_US >= PERIOD_US) begin : g_param_check
        $error("servo_pwm_driver: invalid parameter set");
    end

    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [US_W-1:0]       us_q, us_d;
    logic [3:0][7:0]       cur_angle_q, cur_angle_d;
    logic [3:0][US_W-1:0]  pulse_q, pulse_d;
    logic [3:0]            pwm_q, pwm_d;
    logic                  fs_q, fs_d;
    logic [3:0][7:0]       angle_in;
    logic [3:0][7:0]       target;
    logic [3:0][7:0]       next_angle;
    logic                  latch;

    // The 32-bit product comfortably covers 180 * span without overflow.
    function automatic logic [US_W-1:0] angle_to_us(input logic [7:0] a);
        logic [31:0] prod;
        prod = {24'd0, a} * SPAN;
        return US_W'(MIN32 + prod / 32'd180);
    endfunction

    assign angle_in = {bus.angle4, bus.angle3, bus.angle2, bus.angle1};

    always_comb begin
        target = '0;
        for (int i = 0; i < 4; i++) begin
            target[i] = (angle_in[i] > ANGLE_MAX) ? ANGLE_MAX : angle_in[i];
        end
    end

`ifdef SERVO_SLEW_EN
    localparam logic [7:0] STEP = 8'(SLEW_STEP);

    always_comb begin
        next_angle = cur_angle_q;
        for (int i = 0; i < 4; i++) begin
            if (target[i] > cur_angle_q[i]) begin
                next_angle[i] = (target[i] - cur_angle_q[i] > STEP) ? cur_angle_q[i] + STEP : target[i];
            end else if (target[i] < cur_angle_q[i]) begin
                next_angle[i] = (cur_angle_q[i] - target[i] > STEP) ? cur_angle_q[i] - STEP : target[i];
            end
        end
    end
`else
    assign next_angle = target;
`endif

    assign latch = bus.enable && (pre_q == '0) && (us_q == '0);

    always_comb begin
        pre_d       = pre_q;
        us_d        = us_q;
        cur_angle_d = cur_angle_q;
        pulse_d     = pulse_q;
        pwm_d       = '0;
        fs_d        = latch;

        if (!bus.enable) begin
            pre_d = '0;
            us_d  = '0;
        end else if (pre_q == PRE_LAST) begin
            pre_d = '0;
            us_d  = (us_q == US_LAST) ? '0 : us_q + 1'b1;
        end else begin
            pre_d = pre_q + 1'b1;
        end

        if (latch) begin
            cur_angle_d = next_angle;
            for (int i = 0; i < 4; i++) begin
                pulse_d[i] = angle_to_us(next_angle[i]);
            end
        end

        // Compare against the width already in force; at us_q==0 any width is >0.
        for (int i = 0; i < 4; i++) begin
            pwm_d[i] = bus.enable && (us_q < pulse_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q       <= '0;
            us_q        <= '0;
            cur_angle_q <= {4{ANGLE_RST}};
            pulse_q     <= {4{PULSE_RST}};
            pwm_q       <= '0;
            fs_q        <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            us_q        <= us_d;
            cur_angle_q <= cur_angle_d;
            pulse_q     <= pulse_d;
            pwm_q       <= pwm_d;
            fs_q        <= fs_d;
        end
    end

    assign bus.pwm1          = pwm_q[0];
    assign bus.pwm2          = pwm_q[1];
    assign bus.pwm3          = pwm_q[2];
    assign bus.pwm4          = pwm_q[3];
    assign bus.frame_start   = fs_q;
    assign bus.dbg_cur_angle = cur_angle_q;
endmodule

// File: doc/servo_pwm_driver.md
# servo_pwm_driver

Four-channel hobby-servo PWM generator, the consumer end of the 8-bit servo angle bus. It takes the four angle words (degrees, 0–180) that the switch-driven angle selection logic produces, and drives one 50 Hz PWM line per servo. Each new angle is sampled only at a frame boundary, so no pulse is ever truncated or stretched mid-frame. It sits between the angle selection logic and the board's servo header pins.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency; must be an integer multiple of 1_000_000.
- `PERIOD_US`, 20000: PWM frame length in µs.
- `MIN_PULSE_US`, 1000: pulse width for angle 0.
- `MAX_PULSE_US`, 2000: pulse width for angle 180.
- `SLEW_STEP`, 10: maximum angle change per frame, in degrees. Used only with `SERVO_SLEW_EN`.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  PWM generation enable.
- `angle1`..`angle4`  in  8 each  target angles in degrees, unsigned. Values above 180 are clamped to 180.
- `pwm1`..`pwm4`  out  1 each  servo PWM outputs, registered.
- `frame_start`  out  1  one-clock pulse on the cycle the angles are latched.

## Operation
- **Prescaler** `pre_cnt`:
  - Counts 0..CLK_HZ/1e6−1 and wraps.
  - Its wrap produces a 1 µs tick.
- **Frame counter** `us_cnt`:
  - Counts 0..PERIOD_US−1 on each tick and wraps to 0.
- **Latch condition:** `enable && pre_cnt==0 && us_cnt==0`. On that edge, for each channel:
  - `cur_angle[i] <= next_angle[i]`.
  - `pulse_us[i] <= MIN_PULSE_US + (next_angle[i]*(MAX_PULSE_US−MIN_PULSE_US))/180`, using integer truncation and a ≥18-bit intermediate product.
  - `frame_start <= 1`. It is 0 on every other cycle.
- **Clamping:** `next_angle[i] = min(angle_i, 180)` when `SERVO_SLEW_EN` is not defined.
- **Output:** `pwm_i <= enable && (us_cnt < pulse_us[i])`, using the current counter value and the latched width.
- **Enable low:**
  - `pre_cnt` and `us_cnt` are forced to 0 and all `pwm_i` go to 0 on the next edge.
  - `cur_angle` and `pulse_us` hold their values.
- **Enable rising:** a new frame starts on the first enabled cycle, because the latch condition is true immediately.
- **Simultaneous events:** an angle change on the latch cycle is captured. An angle change on any other cycle takes effect at the next frame.
- **Mid-operation reset:** all state returns to its reset values immediately (asynchronous).

## Timing
- **Reset values:**
  - `pwm1..4`=0, `frame_start`=0, `pre_cnt`=0, `us_cnt`=0.
  - `cur_angle[i]`=90, `pulse_us[i]`=1500 (MIN+(MAX−MIN)/2).
- **Latency:** the angle inputs are sampled on the latch edge. `pwm_i` rises on the following edge, with the same 1-clock lag as `frame_start`.
- **High time:** exactly `pulse_us[i]`×CLK_HZ/1e6 clocks per frame.
- **Frame period:** exactly PERIOD_US×CLK_HZ/1e6 clocks.
- **Pulse alignment:** all four channels rise on the same edge.
- **Angle-0 boundary:** angle 0 still yields MIN_PULSE_US. The output is never constantly low while enabled.

## Configuration
- **Macro:** `SERVO_SLEW_EN`.
- **Defined:** at each latch, `next_angle[i]` steps from `cur_angle[i]` toward the clamped target by at most SLEW_STEP, and never overshoots.
  - Example: 90→180 with step 10 gives 100, 110, …, 180, reaching the target on the 9th latch.
- **Undefined:** `next_angle[i]` is the clamped target directly. The slew comparator and adder are not synthesized.

## Test plan
- **Reset:** CLK_HZ=2_000_000. Assert `rst_n`=0 mid-frame → all `pwm`=0 and `frame_start`=0 asynchronously. After release with `enable`=1, the first `frame_start` occurs 1 clock later and every `pwm` is high for 3000 clocks (1500 µs).
- **Mapping:** `angle1`=0, `angle2`=90, `angle3`=180, `angle4`=200 → high times 2000, 3000, 4000 and 4000 clocks per 40000-clock frame.
- **Mid-frame change:** change `angle1` from 0 to 180 at clock 500 of a frame → current frame high for 2000 clocks, next frame high for 4000 clocks.
- **Enable drop:** drop `enable` at clock 1000 of a frame (during the pulse) → `pwm` is 0 on the next edge. Re-raise `enable` → `frame_start` pulses 1 clock later and a full pulse follows.
- **Slew (`SERVO_SLEW_EN`):** SLEW_STEP=10, step `angle1` from 90 to 180 → latched angles over successive frames are 100, 110, …, 180, then hold at 180. A step from 180 to 175 moves 180→175 in one frame.
- **Period check:** hold all angles constant for 3 frames → `frame_start` spacing is exactly 40000 clocks.
